// File: rtl/mac_bit_column_sequencer.sv
// Walks a registered weight set one bit column at a time, emitting per-group
// activation selects for a bit-serial MAC (skip-zero or skip-one encoding).
//   state | meaning
//   IDLE  | no weight set held, waiting for w_valid
//   RUN   | presenting column col of the held weight set
module mac_bit_column_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         w_valid,
  output logic                         w_ready,
  input  logic signed [DATA_WIDTH-1:0] weight [VEC_LENGTH],
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [3:0]                   act_sel [VEC_LENGTH/2],
  output logic [VEC_LENGTH/8-1:0]      is_skip_zero,
  output logic [2:0]                   column_idx,
  output logic                         is_msb,
  output logic                         load_accum,
  output logic                         last_col,
  output logic                         done
);

  localparam int NG = VEC_LENGTH / 8;
  localparam logic [2:0] COL_LAST = 3'(DATA_WIDTH - 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]                  state;
  logic [2:0]                  col;
  logic signed [DATA_WIDTH-1:0] w_reg [VEC_LENGTH];
  logic [7:0]                  col_bits [NG];
  logic                        run;
  logic                        col_last;

  function automatic logic [3:0] popcount8(input logic [7:0] b);
    logic [3:0] p;
    p = '0;
    for (int l = 0; l < 8; l++) p = p + {3'b000, b[l]};
    return p;
  endfunction

  // Local indices of the first four lanes whose bit equals want; spare slots hold 8 (zero).
  function automatic logic [15:0] pick_lanes(input logic [7:0] b, input logic want);
    logic [15:0] r;
    logic [2:0]  n;
    r = {4{4'd8}};
    n = '0;
    for (int l = 0; l < 8; l++) begin
      if (b[l] == want && n < 3'd4) begin
        r[4*n +: 4] = 4'(l);
        n = n + 3'd1;
      end
    end
    return r;
  endfunction

  assign run       = (state == RUN);
  assign col_last  = (col == COL_LAST);
  assign w_ready   = !run || (col_last && out_ready);
  assign out_valid = run;
  assign column_idx = run ? col : 3'd0;
  assign is_msb     = run && col_last;
  assign last_col   = run && col_last;
  assign load_accum = run && (col == 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      col   <= '0;
      done  <= 1'b0;
      for (int i = 0; i < VEC_LENGTH; i++) w_reg[i] <= '0;
    end else begin
      done <= run && col_last && out_ready;
      if (w_valid && w_ready) begin
        state <= RUN;
        col   <= '0;
        for (int i = 0; i < VEC_LENGTH; i++) w_reg[i] <= weight[i];
      end else if (run && out_ready) begin
        if (col_last) begin
          state <= IDLE;
          col   <= '0;
        end else begin
          col <= col + 3'd1;
        end
      end
    end
  end

  always_comb begin
    for (int g = 0; g < NG; g++) begin
      for (int l = 0; l < 8; l++) col_bits[g][l] = w_reg[8*g+l][col];
    end
  end

  // Dense groups (more than four 1s) select their 0-lanes so at most 3 slots are used.
  always_comb begin
    logic [15:0] slots;
    logic        skip;
    for (int k = 0; k < VEC_LENGTH/2; k++) act_sel[k] = 4'd8;
    is_skip_zero = '1;
    slots = '0;
    skip  = 1'b1;
    if (run) begin
      for (int g = 0; g < NG; g++) begin
        skip = (popcount8(col_bits[g]) <= 4'd4);
        slots = pick_lanes(col_bits[g], skip);
        is_skip_zero[g] = skip;
        for (int k = 0; k < 4; k++) act_sel[4*g+k] = slots[4*k +: 4];
      end
    end
  end

endmodule

// File: tb/tb_mac_bit_column_sequencer.sv
// Self-checking bench for mac_bit_column_sequencer: a scoreboard of expected
// columns filled at each weight handshake, plus directed scenario tasks.
module tb_mac_bit_column_sequencer;

  typedef logic signed [7:0] wset_t [16];
  typedef struct packed {
    logic [2:0]  col;
    logic [1:0]  skip;
    logic [31:0] sel;
    logic        load;
    logic        last;
    logic        msb;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        w_valid = 1'b0;
  logic        w_ready;
  wset_t       w_drive;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  act_sel [8];
  logic [1:0]  is_skip_zero;
  logic [2:0]  column_idx;
  logic        is_msb, load_accum, last_col, done;
  logic [31:0] act_packed;

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  always #5 clk = ~clk;

  mac_bit_column_sequencer #(.DATA_WIDTH(8), .VEC_LENGTH(16)) dut (
    .clk(clk), .reset(reset), .w_valid(w_valid), .w_ready(w_ready),
    .weight(w_drive), .out_valid(out_valid), .out_ready(out_ready),
    .act_sel(act_sel), .is_skip_zero(is_skip_zero), .column_idx(column_idx),
    .is_msb(is_msb), .load_accum(load_accum), .last_col(last_col), .done(done)
  );

  always_comb begin
    for (int k = 0; k < 8; k++) act_packed[4*k +: 4] = act_sel[k];
  end

  function automatic exp_t model(input wset_t w, input int c);
    exp_t e;
    int   p, n;
    e.col  = 3'(c);
    e.load = (c == 0);
    e.last = (c == 7);
    e.msb  = (c == 7);
    e.sel  = {8{4'd8}};
    for (int g = 0; g < 2; g++) begin
      p = 0;
      for (int l = 0; l < 8; l++) p += int'(w[8*g+l][c]);
      e.skip[g] = (p <= 4);
      n = 0;
      for (int l = 0; l < 8; l++) begin
        if (w[8*g+l][c] == e.skip[g] && n < 4) begin
          e.sel[(4*g+n)*4 +: 4] = 4'(l);
          n++;
        end
      end
    end
    return e;
  endfunction

  // Scoreboard: pop on each consumed column, push 8 expected columns on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_column got col=%0d", column_idx);
      end else begin
        e = sb.pop_front();
        if ({column_idx, is_skip_zero, act_packed, load_accum, last_col, is_msb} !== e) begin
          errors++;
          $display("FAIL sb_column got col=%0d skip=%b sel=%h ld=%b lst=%b msb=%b exp col=%0d skip=%b sel=%h ld=%b lst=%b msb=%b",
                   column_idx, is_skip_zero, act_packed, load_accum, last_col, is_msb,
                   e.col, e.skip, e.sel, e.load, e.last, e.msb);
        end
      end
    end
    if (!reset && w_valid && w_ready)
      for (int c = 0; c < 8; c++) sb.push_back(model(w_drive, c));
  end

  task automatic send_set(input wset_t w);
    w_drive = w;
    w_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (w_ready) begin
        @(posedge clk); #1;
        w_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    checks++; errors++;
    $display("FAIL send_set_timeout got w_ready=%b exp 1", w_ready);
    w_valid = 1'b0;
  endtask

  function automatic wset_t fill(input logic [7:0] v);
    wset_t w;
    for (int i = 0; i < 16; i++) w[i] = v;
    return w;
  endfunction

  function automatic wset_t rand_set();
    wset_t w;
    for (int i = 0; i < 16; i++) w[i] = 8'($urandom_range(0, 255));
    return w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    checks++;
    if ({out_valid, w_ready, load_accum, is_msb, last_col, done, column_idx, is_skip_zero, act_packed}
        !== {1'b0, 1'b1, 4'b0000, 3'd0, 2'b11, {8{4'd8}}}) begin
      errors++;
      $display("FAIL reset_state got v=%b rdy=%b ld=%b msb=%b lst=%b done=%b col=%0d skip=%b sel=%h",
               out_valid, w_ready, load_accum, is_msb, last_col, done, column_idx, is_skip_zero, act_packed);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zeros();
    out_ready = 1'b1;
    send_set(fill(8'h00));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (load_accum !== (i == 0)) begin
        errors++; $display("FAIL zeros_load_accum cycle %0d got %b exp %b", i, load_accum, i == 0);
      end
      checks++;
      if (done !== (i == 8)) begin
        errors++; $display("FAIL zeros_done cycle %0d got %b exp %b", i, done, i == 8);
      end
      checks++;
      if (out_valid !== (i < 8)) begin
        errors++; $display("FAIL zeros_out_valid cycle %0d got %b exp %b", i, out_valid, i < 8);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_ones();
    send_set(fill(8'hFF));
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      checks++;
      if (is_msb !== (i == 7) || (i < 8 && (is_skip_zero !== 2'b00 || act_packed !== {8{4'd8}}))) begin
        errors++;
        $display("FAIL ones_column cycle %0d got msb=%b skip=%b sel=%h exp msb=%b skip=00 sel=88888888",
                 i, is_msb, is_skip_zero, act_packed, i == 7);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dense_group();
    wset_t w;
    w = fill(8'h00);
    for (int i = 0; i < 5; i++) w[i] = 8'h7F;
    send_set(w);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (is_skip_zero !== 2'b10 || act_packed !== 32'h8888_8765) begin
          errors++;
          $display("FAIL dense_col0 got skip=%b sel=%h exp skip=10 sel=88888765", is_skip_zero, act_packed);
        end
      end
      if (i == 7) begin
        checks++;
        if (is_skip_zero !== 2'b11 || act_packed !== {8{4'd8}}) begin
          errors++;
          $display("FAIL dense_col7 got skip=%b sel=%h exp skip=11 sel=88888888", is_skip_zero, act_packed);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sparse_lanes();
    wset_t w;
    w = fill(8'h00);
    w[9] = 8'h01;
    w[3] = 8'h80;
    send_set(w);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (act_packed !== 32'h8881_8888) begin
          errors++; $display("FAIL sparse_col0 got sel=%h exp 88818888", act_packed);
        end
      end
      if (i == 7) begin
        checks++;
        if (act_packed !== 32'h8888_8883) begin
          errors++; $display("FAIL sparse_col7 got sel=%h exp 88888883", act_packed);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_stall();
    wset_t w;
    exp_t  e4;
    int    cnt;
    w  = rand_set();
    e4 = model(w, 4);
    cnt = 0;
    send_set(w);
    for (int i = 0; i < 16; i++) begin
      out_ready = !(i >= 4 && i <= 6);
      @(negedge clk);
      if (out_valid) cnt++;
      if (i >= 4 && i <= 6) begin
        checks++;
        if (column_idx !== 3'd4 || act_packed !== e4.sel) begin
          errors++;
          $display("FAIL stall_hold cycle %0d got col=%0d sel=%h exp col=4 sel=%h", i, column_idx, act_packed, e4.sel);
        end
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    checks++;
    if (cnt !== 11) begin
      errors++; $display("FAIL stall_cycles got %0d exp 11", cnt);
    end
  endtask

  task automatic test_back_to_back();
    wset_t wa, wb;
    wa = rand_set();
    wb = rand_set();
    send_set(wa);
    w_drive = wb;
    w_valid = 1'b1;
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== (i < 16) || done !== (i == 8 || i == 16)) begin
        errors++;
        $display("FAIL b2b_flow cycle %0d got v=%b done=%b exp v=%b done=%b", i, out_valid, done, i < 16, i == 8 || i == 16);
      end
      if (i == 7) begin
        checks++;
        if (w_ready !== 1'b1 || last_col !== 1'b1) begin
          errors++; $display("FAIL b2b_handoff got rdy=%b last=%b exp 1 1", w_ready, last_col);
        end
      end
      if (i == 8) begin
        checks++;
        if (column_idx !== 3'd0 || load_accum !== 1'b1) begin
          errors++; $display("FAIL b2b_next_col0 got col=%0d ld=%b exp col=0 ld=1", column_idx, load_accum);
        end
      end
      @(posedge clk); #1;
      if (i == 7) w_valid = 1'b0;
    end
  endtask

  task automatic test_reset_mid_run();
    send_set(rand_set());
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (column_idx !== 3'd3) begin
      errors++; $display("FAIL midreset_col got %0d exp 3", column_idx);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    checks++;
    if ({out_valid, w_ready, load_accum, is_msb, last_col, done, is_skip_zero, act_packed}
        !== {1'b0, 1'b1, 4'b0000, 2'b11, {8{4'd8}}}) begin
      errors++;
      $display("FAIL midreset_state got v=%b rdy=%b ld=%b msb=%b lst=%b done=%b skip=%b sel=%h",
               out_valid, w_ready, load_accum, is_msb, last_col, done, is_skip_zero, act_packed);
    end
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int  sent;
    bit  acc;
    bit  drained;
    sent = 0;
    w_drive = rand_set();
    w_valid = 1'b1;
    for (int i = 0; i < 400 && sent < 4; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = w_valid && w_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        w_drive = rand_set();
        if (sent == 4) w_valid = 1'b0;
      end
    end
    w_valid = 1'b0;
    out_ready = 1'b1;
    drained = 1'b0;
    for (int i = 0; i < 40 && !drained; i++) begin
      @(negedge clk);
      if (!out_valid) drained = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (sent !== 4 || !drained) begin
      errors++; $display("FAIL random_progress got sets=%0d drained=%b exp 4 1", sent, drained);
    end
  endtask

  initial begin
    w_drive = fill(8'h00);
    test_reset();
    test_zeros();
    test_ones();
    test_dense_group();
    test_sparse_lanes();
    test_stall();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    repeat (2) @(posedge clk);
    checks++;
    if (sb.size() !== 0) begin
      errors++; $display("FAIL sb_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
